mem_stage: RTL and testbench

- Memory-access stage directly downstream of the exec stage in the 5-stage pipeline.
- Accepts exec's control and data outputs and performs loads/stores against a handshaked data memory.
- Load results are size/sign-extended; branch/jump redirect is resolved from Branch/Zero/Jump.
- Results are registered into the MEM/WB pipeline register for writeback.

---
 rtl/mem_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : Pipeline memory-access stage. Performs handshaked loads/stores
//             with size/sign extension and alignment checks, resolves the
//             branch/jump redirect, and feeds the MEM/WB pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MemWr,
  input  logic              MemtoReg,
  input  logic              RegWr,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              Jal,
  input  logic              Zero,
  input  logic              Loadext,
  input  logic [1:0]        Dsize,
  input  logic [1:0]        FPoint,
  input  logic [31:0]       ALUout,
  input  logic [31:0]       BusB,
  input  logic [4:0]        Rw,
  input  logic [31:0]       BranchTarget,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic              misalign,
  output logic              bus_err,
  output logic              wb_valid,
  output logic              wb_RegWr,
  output logic              wb_MemtoReg,
  output logic              wb_Jal,
  output logic [1:0]        wb_FPoint,
  output logic [4:0]        wb_Rw,
  output logic [31:0]       wb_ALUout,
  output logic [31:0]       wb_MemData
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;

  // Controls captured for the access in flight
  logic        cap_regwr;
  logic        cap_memtoreg;
  logic        cap_jal;
  logic        cap_loadext;
  logic [1:0]  cap_dsize;
  logic [1:0]  cap_fpoint;
  logic [4:0]  cap_rw;
  logic [31:0] cap_alu;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        start_access;
  logic        retire_direct;
  logic        timed_out;
  logic        wait_done;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // Reserved size 2'b11 falls into the word cases everywhere below.
  assign in_ready      = (state == IDLE) & rst_n;
  assign accept        = in_valid & in_ready;
  assign is_mem        = MemWr | MemtoReg;
  assign misaligned    = is_mem & (((Dsize == 2'b01) & ALUout[0]) |
                                   (Dsize[1] == Dsize[0] & (|ALUout[1:0])));
  assign start_access  = accept & is_mem & ~misaligned;
  assign retire_direct = accept & ~start_access;
  assign timed_out     = (state == WAIT) & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));
  assign wait_done     = (state == WAIT) & (dmem_ack | timed_out);

  // Little-endian byte enables and lane-replicated store data
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = BusB;
    case (Dsize)
      2'b10: begin
        be_calc    = 4'b0001 << ALUout[1:0];
        wdata_calc = {4{BusB[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << ALUout[1:0];
        wdata_calc = {2{BusB[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = BusB;
      end
    endcase
  end

  // Select the addressed lane of read data and extend it to 32 bits
  always_comb begin
    rd_shifted = dmem_rdata >> {cap_alu[1:0], 3'b000};
    load_ext   = dmem_rdata;
    case (cap_dsize)
      2'b10:   load_ext = {{24{cap_loadext & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = {{16{cap_loadext & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state: aligned memory ops wait for ack or timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_access) state_nx = WAIT;
      WAIT:    if (wait_done)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Timeout counter: cleared on access start, counts WAIT cycles without ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_access || wait_done) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Memory request interface and captured controls, held for the whole WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= 32'h0;
      cap_regwr    <= 1'b0;
      cap_memtoreg <= 1'b0;
      cap_jal      <= 1'b0;
      cap_loadext  <= 1'b0;
      cap_dsize    <= 2'b00;
      cap_fpoint   <= 2'b00;
      cap_rw       <= 5'd0;
      cap_alu      <= 32'h0;
    end else if (start_access) begin
      dmem_req     <= 1'b1;
      dmem_we      <= MemWr;
      dmem_addr    <= ADDR_W'({ALUout[31:2], 2'b00});
      dmem_be      <= be_calc;
      dmem_wdata   <= wdata_calc;
      cap_regwr    <= RegWr;
      cap_memtoreg <= MemtoReg;
      cap_jal      <= Jal;
      cap_loadext  <= Loadext;
      cap_dsize    <= Dsize;
      cap_fpoint   <= FPoint;
      cap_rw       <= Rw;
      cap_alu      <= ALUout;
    end else if (wait_done) begin
      dmem_req     <= 1'b0;
    end
  end

  // MEM/WB register: retire direct ops at accept, memory ops at ack/timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_RegWr    <= 1'b0;
      wb_MemtoReg <= 1'b0;
      wb_Jal      <= 1'b0;
      wb_FPoint   <= 2'b00;
      wb_Rw       <= 5'd0;
      wb_ALUout   <= 32'h0;
      wb_MemData  <= 32'h0;
    end else begin
      wb_valid <= 1'b0;
      wb_RegWr <= 1'b0;
      if (retire_direct) begin
        wb_valid    <= 1'b1;
        wb_RegWr    <= RegWr & ~misaligned;
        wb_MemtoReg <= MemtoReg;
        wb_Jal      <= Jal;
        wb_FPoint   <= FPoint;
        wb_Rw       <= Rw;
        wb_ALUout   <= ALUout;
      end else if (wait_done) begin
        wb_valid    <= 1'b1;
        wb_RegWr    <= cap_regwr & dmem_ack;
        wb_MemtoReg <= cap_memtoreg;
        wb_Jal      <= cap_jal;
        wb_FPoint   <= cap_fpoint;
        wb_Rw       <= cap_rw;
        wb_ALUout   <= cap_alu;
        if (dmem_ack) wb_MemData <= load_ext;
      end
    end
  end

  // One-cycle status pulses: redirect, misalignment and bus timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_src    <= 1'b0;
      pc_target <= 32'h0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      pc_src   <= accept & ((Branch & Zero) | Jump);
      misalign <= accept & misaligned;
      bus_err  <= timed_out;
      if (accept && ((Branch && Zero) || Jump)) pc_target <= BranchTarget;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Self-checking bench for mem_stage: directed and random
//             instructions, scoreboard queues checked by a separate monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic        MemWr, MemtoReg, RegWr, Branch, Jump, Jal, Zero, Loadext;
  logic [1:0]  Dsize, FPoint;
  logic [31:0] ALUout, BusB, BranchTarget;
  logic [4:0]  Rw;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        pc_src, misalign, bus_err;
  logic [31:0] pc_target;
  logic        wb_valid, wb_RegWr, wb_MemtoReg, wb_Jal;
  logic [1:0]  wb_FPoint;
  logic [4:0]  wb_Rw;
  logic [31:0] wb_ALUout, wb_MemData;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .RegWr(RegWr), .Branch(Branch),
    .Jump(Jump), .Jal(Jal), .Zero(Zero), .Loadext(Loadext), .Dsize(Dsize),
    .FPoint(FPoint), .ALUout(ALUout), .BusB(BusB), .Rw(Rw),
    .BranchTarget(BranchTarget), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .pc_src(pc_src),
    .pc_target(pc_target), .misalign(misalign), .bus_err(bus_err),
    .wb_valid(wb_valid), .wb_RegWr(wb_RegWr), .wb_MemtoReg(wb_MemtoReg),
    .wb_Jal(wb_Jal), .wb_FPoint(wb_FPoint), .wb_Rw(wb_Rw),
    .wb_ALUout(wb_ALUout), .wb_MemData(wb_MemData)
  );

  typedef struct {
    logic        memwr, memtoreg, regwr, branch, jump, jal, zero, loadext;
    logic [1:0]  dsize, fpoint;
    logic [31:0] aluout, busb, btarget, rdata;
    logic [4:0]  rw;
    int          ack_delay;   // WAIT cycle carrying ack; 0 = never ack
    bit          rst_mid;     // pull reset in the 2nd WAIT cycle
  } instr_t;

  typedef struct {
    logic        regwr, memtoreg, jal;
    logic [1:0]  fpoint;
    logic [4:0]  rw;
    logic [31:0] aluout, memdata;
    bit          chk_mem, mis, berr;
  } wb_t;

  wb_t         wb_q[$];
  logic [31:0] redir_q[$];
  wb_t         mon_e;
  logic [31:0] mon_t;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int nbytes(logic [1:0] ds);
    if (ds == 2'b10) return 1;
    if (ds == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] ds, int a);
    int m;
    m = ((1 << nbytes(ds)) - 1) << a;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(logic [1:0] ds, logic [31:0] d);
    int n;
    logic [31:0] r;
    n = nbytes(ds);
    r = d;
    for (int i = 0; i < 4; i++) r = r & ~(32'hFF << (8 * i)) | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] ds, int a, logic ext, logic [31:0] rd);
    int n;
    longint unsigned v, mask;
    n = nbytes(ds);
    if (n == 4) return rd;
    mask = (64'd1 << (8 * n)) - 1;
    v = (64'(rd) >> (8 * a)) & mask;
    if (ext && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t.memwr = 0; t.memtoreg = 0; t.regwr = 0; t.branch = 0; t.jump = 0;
    t.jal = 0; t.zero = 0; t.loadext = 0; t.dsize = 0; t.fpoint = 0;
    t.aluout = 0; t.busb = 0; t.btarget = 0; t.rdata = 0; t.rw = 0;
    t.ack_delay = 1; t.rst_mid = 0;
    return t;
  endfunction

  // ---------------- driver + memory responder ----------------
  task automatic send(input instr_t t);
    bit  mem, mis;
    int  a;
    wb_t e;
    mem = t.memwr | t.memtoreg;
    a   = int'(t.aluout[1:0]);
    mis = mem && ((a % nbytes(t.dsize)) != 0);
    e.regwr = t.regwr & ~mis; e.memtoreg = t.memtoreg; e.jal = t.jal;
    e.fpoint = t.fpoint; e.rw = t.rw; e.aluout = t.aluout; e.memdata = 0;
    e.chk_mem = 0; e.mis = mis; e.berr = 0;

    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 1);
    in_valid = 1; MemWr = t.memwr; MemtoReg = t.memtoreg; RegWr = t.regwr;
    Branch = t.branch; Jump = t.jump; Jal = t.jal; Zero = t.zero;
    Loadext = t.loadext; Dsize = t.dsize; FPoint = t.fpoint;
    ALUout = t.aluout; BusB = t.busb; Rw = t.rw; BranchTarget = t.btarget;
    if (!mem || mis) wb_q.push_back(e);
    if ((t.branch && t.zero) || t.jump) redir_q.push_back(t.btarget);
    @(posedge clk); #1;
    in_valid = 0;

    if (mem && !mis) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        @(negedge clk);
        check("dmem_req_wait", {31'b0, dmem_req}, 1);
        check("in_ready_wait", {31'b0, in_ready}, 0);
        check("dmem_we", {31'b0, dmem_we}, {31'b0, t.memwr});
        check("dmem_addr", dmem_addr, {t.aluout[31:2], 2'b00});
        check("dmem_be", {28'b0, dmem_be}, {28'b0, model_be(t.dsize, a)});
        if (t.memwr) check("dmem_wdata", dmem_wdata, model_wdata(t.dsize, t.busb));
        if (t.rst_mid && k == 2) begin
          rst_n = 0;
          #1;
          check("rst_dmem_req", {31'b0, dmem_req}, 0);
          check("rst_in_ready", {31'b0, in_ready}, 0);
          check("rst_wb_valid", {31'b0, wb_valid}, 0);
          check("rst_dmem_addr", dmem_addr, 0);
          check("rst_wb_aluout", wb_ALUout, 0);
          @(posedge clk); #1;
          rst_n = 1;
          return;
        end
        if (k == t.ack_delay) begin
          dmem_ack = 1; dmem_rdata = t.rdata;
          e.memdata = model_load(t.dsize, a, t.loadext, t.rdata);
          e.chk_mem = t.memtoreg;
          wb_q.push_back(e);
          @(posedge clk); #1;
          dmem_ack = 0; dmem_rdata = $urandom;
          break;
        end
        if (k == TIMEOUT) begin
          e.regwr = 0; e.berr = 1;
          wb_q.push_back(e);
        end
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("dmem_req_after", {31'b0, dmem_req}, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_wb: got wb_valid=1 expected no retirement at %0t", $time);
        end else begin
          mon_e = wb_q.pop_front();
          check("wb_RegWr", {31'b0, wb_RegWr}, {31'b0, mon_e.regwr});
          check("wb_MemtoReg", {31'b0, wb_MemtoReg}, {31'b0, mon_e.memtoreg});
          check("wb_Jal", {31'b0, wb_Jal}, {31'b0, mon_e.jal});
          check("wb_FPoint", {30'b0, wb_FPoint}, {30'b0, mon_e.fpoint});
          check("wb_Rw", {27'b0, wb_Rw}, {27'b0, mon_e.rw});
          check("wb_ALUout", wb_ALUout, mon_e.aluout);
          if (mon_e.chk_mem) check("wb_MemData", wb_MemData, mon_e.memdata);
          check("misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
          check("bus_err", {31'b0, bus_err}, {31'b0, mon_e.berr});
        end
      end else begin
        check("wb_RegWr_idle", {31'b0, wb_RegWr}, 0);
        check("misalign_idle", {31'b0, misalign}, 0);
        check("bus_err_idle", {31'b0, bus_err}, 0);
      end
      if (pc_src) begin
        if (redir_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_pc_src: got pc_src=1 expected 0 at %0t", $time);
        end else begin
          mon_t = redir_q.pop_front();
          check("pc_target", pc_target, mon_t);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t t;
    int     r;
    in_valid = 0; MemWr = 0; MemtoReg = 0; RegWr = 0; Branch = 0; Jump = 0;
    Jal = 0; Zero = 0; Loadext = 0; Dsize = 0; FPoint = 0; ALUout = 0;
    BusB = 0; Rw = 0; BranchTarget = 0; dmem_rdata = 0; dmem_ack = 0;
    rst_n = 0;
    #12;
    check("reset_in_ready", {31'b0, in_ready}, 0);
    check("reset_dmem_req", {31'b0, dmem_req}, 0);
    check("reset_wb_valid", {31'b0, wb_valid}, 0);
    check("reset_pc_src", {31'b0, pc_src}, 0);
    check("reset_wb_aluout", wb_ALUout, 0);
    check("reset_wb_memdata", wb_MemData, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // ALU op, latency 1, no memory request
    t = blank(); t.regwr = 1; t.rw = 5; t.aluout = 32'h1234;
    send(t);
    // Byte loads at 0x103: signed then unsigned
    t = blank(); t.memtoreg = 1; t.regwr = 1; t.dsize = 2'b10; t.loadext = 1;
    t.aluout = 32'h103; t.ack_delay = 2; t.rdata = 32'h80FF_FFFF; t.rw = 7;
    send(t);
    t.loadext = 0;
    send(t);
    // Half store at 0x202, ack in first WAIT cycle
    t = blank(); t.memwr = 1; t.dsize = 2'b01; t.busb = 32'hABCD_1234;
    t.aluout = 32'h202; t.ack_delay = 1;
    send(t);
    // Misaligned word load combined with a taken branch
    t = blank(); t.memtoreg = 1; t.regwr = 1; t.dsize = 2'b00; t.aluout = 32'h6;
    t.branch = 1; t.zero = 1; t.btarget = 32'h400;
    send(t);
    // Untaken branch: no redirect
    t = blank(); t.branch = 1; t.zero = 0; t.btarget = 32'h800; t.regwr = 1;
    send(t);
    // Load with no ack: timeout and bus error
    t = blank(); t.memtoreg = 1; t.regwr = 1; t.aluout = 32'h40; t.ack_delay = 0;
    send(t);
    // Reset in the middle of WAIT, then a normal instruction
    t = blank(); t.memtoreg = 1; t.regwr = 1; t.aluout = 32'h80; t.ack_delay = 5;
    t.rst_mid = 1;
    send(t);
    t = blank(); t.regwr = 1; t.rw = 9; t.aluout = 32'hCAFE_0000; t.jump = 1;
    t.btarget = 32'h1000;
    send(t);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      t = blank();
      r = $urandom_range(0, 2);
      t.memtoreg = (r == 1); t.memwr = (r == 2);
      t.regwr = $urandom_range(0, 1); t.jal = $urandom_range(0, 1);
      t.branch = $urandom_range(0, 1); t.zero = $urandom_range(0, 1);
      t.jump = ($urandom_range(0, 7) == 0); t.loadext = $urandom_range(0, 1);
      t.dsize = 2'($urandom_range(0, 3)); t.fpoint = 2'($urandom_range(0, 3));
      t.aluout = $urandom; t.busb = $urandom; t.btarget = $urandom;
      t.rdata = $urandom; t.rw = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) t.aluout[1:0] = 2'b00;
      t.ack_delay = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4);
      send(t);
    end

    repeat (3) @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("redir_queue_drained", redir_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
